// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, datapath widths and operand-usage helper.
package mips_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // True when the opcode reads rt as a source operand (not just as a destination).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the ID instruction reads a register that the load in EX
// has not yet written. Purely combinational so forwarding logic can share it.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       valid_i,
    input  logic       mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [5:0] op_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic       lu_o
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        lu_o = valid_i && mem_read_i && (ex_rt_i != 5'd0) &&
               ((ex_rt_i == rs_i) || (uses_rt(op_i) && (ex_rt_i == rt_i)));
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, J/JAL redirect, branch flush and
// saturating debug counters for stall and flush events.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               branch_flag,
    input  logic               id_ex_mem_read,
    input  logic [4:0]         id_ex_rt,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    pc_plus1_q,
    output logic               id_valid,
    output logic               hazard_n,
    output logic               jump_flag,
    output logic [PC_W-1:0]    jump_pc,
    output logic               jal_flag,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_plus1_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               lu;
    logic [5:0]         op;
    logic               is_jump;

    assign op = instr_q[31:26];

    hazard_detect u_hazard (
        .valid_i    (valid_q),
        .mem_read_i (id_ex_mem_read),
        .ex_rt_i    (id_ex_rt),
        .op_i       (op),
        .rs_i       (instr_q[25:21]),
        .rt_i       (instr_q[20:16]),
        .lu_o       (lu)
    );

    // Fetch-facing controls; a taken branch kills the ID instruction, so it neither stalls nor jumps.
    always_comb begin
        is_jump   = (op == OP_J) || (op == OP_JAL);
        hazard_n  = ~(lu & ~branch_flag);
        id_valid  = valid_q & ~lu & ~branch_flag;
        jump_flag = id_valid & is_jump;
        jal_flag  = jump_flag & (op == OP_JAL);
        jump_pc   = instr_q[PC_W-1:0];
    end

    // Next-state: branch reload beats stall hold beats normal advance; counters saturate.
    always_comb begin
        instr_d     = instr_in;
        pc_plus1_d  = pc_in + 10'd1;
        valid_d     = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (branch_flag) begin
            if (valid_q && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (lu) begin
            instr_d    = instr_q;
            pc_plus1_d = pc_plus1_q;
            valid_d    = valid_q;
            if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset to a NOP bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= NOP;
            pc_plus1_q  <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_plus1_q  <= pc_plus1_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a reference model predicts the registered state
// each edge into a scoreboard queue; combinational outputs are checked against constants.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic [9:0]  pc_in;
    logic        branch_flag, id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [31:0] instr_q;
    logic [9:0]  pc_plus1_q, jump_pc;
    logic        id_valid, hazard_n, jump_flag, jal_flag;
    logic [15:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc1;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sbq[$];
    exp_t m;

    always #5 clk = ~clk;

    if_id_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .branch_flag(branch_flag), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .instr_q(instr_q), .pc_plus1_q(pc_plus1_q), .id_valid(id_valid), .hazard_n(hazard_n),
        .jump_flag(jump_flag), .jump_pc(jump_pc), .jal_flag(jal_flag),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load-use decision written straight from the operand rules.
    function automatic logic model_lu(input exp_t s);
        logic [5:0] op;
        logic       rt_src;
        op     = s.instr[31:26];
        rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        if (!s.valid || !id_ex_mem_read || id_ex_rt == 5'd0) return 1'b0;
        return (id_ex_rt == s.instr[25:21]) || (rt_src && id_ex_rt == s.instr[20:16]);
    endfunction

    // Predict next state from current inputs, push it, clock, then pop and compare.
    task automatic tick();
        exp_t nx, got;
        nx = m;
        if (reset) begin
            nx = '{32'h0, 10'd0, 1'b0, 16'd0, 16'd0};
        end else if (branch_flag) begin
            nx.instr = instr_in; nx.pc1 = pc_in + 10'd1; nx.valid = 1'b1;
            if (m.valid && m.fc != 16'hFFFF) nx.fc = m.fc + 16'd1;
        end else if (model_lu(m)) begin
            if (m.sc != 16'hFFFF) nx.sc = m.sc + 16'd1;
        end else begin
            nx.instr = instr_in; nx.pc1 = pc_in + 10'd1; nx.valid = 1'b1;
        end
        sbq.push_back(nx);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        chk("instr_q",    instr_q,    got.instr);
        chk("pc_plus1_q", {22'd0, pc_plus1_q}, {22'd0, got.pc1});
        chk("stall_cnt",  {16'd0, stall_cnt},  {16'd0, got.sc});
        chk("flush_cnt",  {16'd0, flush_cnt},  {16'd0, got.fc});
        m = got;
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [9:0] pc,
                         input logic br, input logic mr, input logic [4:0] rt);
        instr_in = ins; pc_in = pc; branch_flag = br; id_ex_mem_read = mr; id_ex_rt = rt;
        #1;
    endtask

    // Directed check of the fetch-facing combinational outputs.
    task automatic comb(input string tag, input logic hn, input logic idv,
                        input logic jf, input logic jl, input logic [9:0] jpc);
        chk({tag, ".hazard_n"},  {31'd0, hazard_n},  {31'd0, hn});
        chk({tag, ".id_valid"},  {31'd0, id_valid},  {31'd0, idv});
        chk({tag, ".jump_flag"}, {31'd0, jump_flag}, {31'd0, jf});
        chk({tag, ".jal_flag"},  {31'd0, jal_flag},  {31'd0, jl});
        chk({tag, ".jump_pc"},   {22'd0, jump_pc},   {22'd0, jpc});
    endtask

    initial begin
        m = '{32'h0, 10'd0, 1'b0, 16'd0, 16'd0};
        reset = 1'b1;
        drive(32'hDEADBEEF, 10'd77, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        comb("reset", 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

        // First fetched instruction
        drive(32'h8C010004, 10'd5, 1'b0, 1'b0, 5'd0);
        tick();
        chk("first.instr", instr_q, 32'h8C010004);
        chk("first.pc1", {22'd0, pc_plus1_q}, 32'd6);
        comb("first", 1'b1, 1'b1, 1'b0, 1'b0, 10'h004);

        // Load-use stall on rs of add $3,$1,$2
        drive(32'h00221820, 10'd6, 1'b0, 1'b0, 5'd0);
        tick();
        drive(32'h11111111, 10'd7, 1'b0, 1'b1, 5'd1);
        comb("lu", 1'b0, 1'b0, 1'b0, 1'b0, 10'h020);
        tick();
        chk("lu.hold", instr_q, 32'h00221820);
        chk("lu.stall_cnt", {16'd0, stall_cnt}, 32'd1);
        drive(32'h8C220000, 10'd7, 1'b0, 1'b0, 5'd0);
        comb("lu.release", 1'b1, 1'b1, 1'b0, 1'b0, 10'h020);
        tick();

        // LW uses only rs: a load into its rt ($2) is not a hazard
        drive(32'h00221820, 10'd8, 1'b0, 1'b1, 5'd2);
        comb("lw_rt", 1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        tick();
        // Load into $0 never stalls
        drive(32'h8C020008, 10'd9, 1'b0, 1'b1, 5'd0);
        comb("rt0", 1'b1, 1'b1, 1'b0, 1'b0, 10'h020);
        tick();

        // JAL redirect
        drive(32'h0C000123, 10'd10, 1'b0, 1'b0, 5'd0);
        tick();
        comb("jal", 1'b1, 1'b1, 1'b1, 1'b1, 10'h123);
        drive(32'h00000000, 10'h123, 1'b0, 1'b0, 5'd0);
        tick();
        chk("jal.target", {22'd0, pc_plus1_q}, 32'h124);

        // J with rs=$1 under a load-use hazard, then a taken branch overrides
        drive(32'h08200040, 10'h124, 1'b0, 1'b0, 5'd0);
        tick();
        drive(32'h55555555, 10'h125, 1'b0, 1'b1, 5'd1);
        comb("j_lu", 1'b0, 1'b0, 1'b0, 1'b0, 10'h040);
        drive(32'h8C030000, 10'h200, 1'b1, 1'b1, 5'd1);
        comb("branch", 1'b1, 1'b0, 1'b0, 1'b0, 10'h040);
        tick();
        chk("branch.instr", instr_q, 32'h8C030000);
        chk("branch.flush", {16'd0, flush_cnt}, 32'd1);

        // PC wrap
        drive(32'h00000000, 10'd1023, 1'b0, 1'b0, 5'd0);
        tick();
        chk("wrap.pc1", {22'd0, pc_plus1_q}, 32'd0);

        // Counter saturation: hold a permanent stall past 65535 events
        drive(32'h00221820, 10'd5, 1'b0, 1'b0, 5'd0);
        tick();
        drive(32'h00000000, 10'd6, 1'b0, 1'b1, 5'd1);
        for (int i = 0; i < 65540; i++) tick();
        chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Reset mid-stall clears everything in one edge
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        comb("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
        chk("rst_mid.stall_cnt", {16'd0, stall_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
